// File: rtl/pio_pkg.sv
// Shared constants for the Avalon-MM open-drain PIO: register word addresses,
// edge-capture encodings and the prime-counter sizing helper.
package pio_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_DIR     = 3'd1,
    ADDR_IRQMASK = 3'd2,
    ADDR_EDGECAP = 3'd3,
    ADDR_OUTSET  = 3'd4,
    ADDR_OUTCLR  = 3'd5
  } pio_addr_e;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Bits needed to count from 0 up to sync_stages+1 inclusive.
  function automatic int unsigned prime_cnt_width(input int unsigned sync_stages);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) <= sync_stages + 1) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Pin input synchroniser with one-cycle history and edge detection; edges are
// suppressed until the chain has been refilled with real pin samples after reset.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_ANY
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_det
);

  localparam int unsigned    CW         = prime_cnt_width(SYNC_STAGES);
  localparam logic [CW-1:0]  PRIME_DONE = CW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_d, prev_q;
  logic [CW-1:0]    prime_d, prime_q;
  logic [WIDTH-1:0] rise, fall;

  always_comb begin
    sync_d[0] = pad_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d  = sync_q[SYNC_STAGES-1];
    prime_d = (prime_q == PRIME_DONE) ? prime_q : prime_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q  <= '0;
      prime_q <= '0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q  <= prev_d;
      prime_q <= prime_d;
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Held off until prev_q holds a genuine pin sample, so pins high at reset stay quiet.
  always_comb begin
    rise     = sync_in & ~prev_q;
    fall     = ~sync_in & prev_q;
    edge_det = '0;
    if (prime_q == PRIME_DONE) begin
      case (EDGE_TYPE)
        EDGE_RISE: edge_det = rise;
        EDGE_FALL: edge_det = fall;
        default:   edge_det = rise | fall;
      endcase
    end
  end

endmodule

// File: rtl/avalon_pio_od.sv
// Avalon-MM GPIO port: per-bit direction, open-drain or push-pull pins,
// synchronised inputs, edge capture with write-1-to-clear and a masked irq.
module avalon_pio_od
  import pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      OPEN_DRAIN  = 1,
  parameter int unsigned      EDGE_TYPE   = EDGE_ANY,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic             irq
);

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;

  logic [WIDTH-1:0] data_out_d, data_out_q;
  logic [WIDTH-1:0] dir_d, dir_q;
  logic [WIDTH-1:0] irqmask_d, irqmask_q;
  logic [WIDTH-1:0] edgecap_d, edgecap_q;
  logic [WIDTH-1:0] edgecap_clr;
  logic             irq_d, irq_q;

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] rd_word;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .pad_in   (pad_in),
    .sync_in  (sync_in),
    .edge_det (edge_det)
  );

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_out_d  = data_out_q;
    dir_d       = dir_q;
    irqmask_d   = irqmask_q;
    edgecap_clr = '0;
    if (wr_en) begin
      case (pio_addr_e'(address))
        ADDR_DATA:    data_out_d  = wd;
        ADDR_DIR:     dir_d       = wd;
        ADDR_IRQMASK: irqmask_d   = wd;
        ADDR_EDGECAP: edgecap_clr = wd;
        ADDR_OUTSET:  data_out_d  = data_out_q | wd;
        ADDR_OUTCLR:  data_out_d  = data_out_q & ~wd;
        default:      ;
      endcase
    end
    // OR-ing the new edges in after the clear lets a coincident edge survive it.
    edgecap_d = (edgecap_q & ~edgecap_clr) | edge_det;
    irq_d     = |(edgecap_q & irqmask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_VALUE;
      dir_q      <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    rd_word = '0;
    case (pio_addr_e'(address))
      ADDR_DATA:    rd_word = sync_in;
      ADDR_DIR:     rd_word = dir_q;
      ADDR_IRQMASK: rd_word = irqmask_q;
      ADDR_EDGECAP: rd_word = edgecap_q;
      ADDR_OUTSET:  rd_word = data_out_q;
      ADDR_OUTCLR:  rd_word = data_out_q;
      default:      rd_word = '0;
    endcase
    readdata               = '0;
    readdata[WIDTH-1:0]    = rd_word;
  end

  generate
    if (OPEN_DRAIN != 0) begin : g_open_drain
      assign pad_out = '0;
      assign pad_oe  = dir_q & ~data_out_q;
    end else begin : g_push_pull
      assign pad_out = data_out_q;
      assign pad_oe  = dir_q;
    end
  endgenerate

endmodule

// File: tb/tb_avalon_pio_od.sv
// Randomised and directed bench for avalon_pio_od: two instances (open-drain/any-edge
// and push-pull/rise-only) checked every cycle against a time-indexed reference model.
module tb_avalon_pio_od;

  localparam int         W    = 8;
  localparam int         S    = 2;
  localparam logic [7:0] RV_B = 8'h5A;
  localparam int         ET [2] = '{2, 0};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  pad_in;

  logic [31:0] rd_a, rd_b;
  logic [7:0]  po_a, oe_a, po_b, oe_b;
  logic        irq_a, irq_b;

  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  avalon_pio_od #(
    .WIDTH(W), .RESET_VALUE(8'h00), .OPEN_DRAIN(1), .EDGE_TYPE(2), .SYNC_STAGES(S)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .pad_in(pad_in),
    .pad_out(po_a), .pad_oe(oe_a), .irq(irq_a)
  );

  avalon_pio_od #(
    .WIDTH(W), .RESET_VALUE(RV_B), .OPEN_DRAIN(0), .EDGE_TYPE(0), .SYNC_STAGES(S)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b), .pad_in(pad_in),
    .pad_out(po_b), .pad_oe(oe_b), .irq(irq_b)
  );

  // Reference model: hist[j] is the pin value sampled at clock j after reset release.
  int         n;
  logic [7:0] hist [0:8191];
  logic [7:0] m_dir, m_mask;
  logic [7:0] m_data [2];
  logic [7:0] m_ecap [2];
  logic       m_irq  [2];

  function automatic logic [7:0] sync_at(input int m);
    int idx;
    idx = m - S + 1;
    if (idx >= 1) return hist[idx];
    return 8'h00;
  endfunction

  function automatic logic [7:0] edge_vec(input int et, input logic [7:0] cur, input logic [7:0] prv);
    if (et == 0) return cur & ~prv;
    if (et == 1) return ~cur & prv;
    return cur ^ prv;
  endfunction

  task automatic model_reset();
    n         = 0;
    m_dir     = 8'h00;
    m_mask    = 8'h00;
    m_data[0] = 8'h00;
    m_data[1] = RV_B;
    for (int k = 0; k < 2; k++) begin
      m_ecap[k] = 8'h00;
      m_irq[k]  = 1'b0;
    end
  endtask

  task automatic model_step();
    logic       wr;
    logic [7:0] wd, cur, prv, ev, clr;
    wr  = chipselect && !write_n;
    wd  = writedata[7:0];
    cur = sync_at(n);
    prv = sync_at(n - 1);
    clr = (wr && address == 3'd3) ? wd : 8'h00;
    for (int k = 0; k < 2; k++) begin
      ev        = (n >= S + 1) ? edge_vec(ET[k], cur, prv) : 8'h00;
      m_irq[k]  = (m_ecap[k] & m_mask) != 8'h00;
      m_ecap[k] = (m_ecap[k] & ~clr) | ev;
      if (wr) begin
        case (address)
          3'd0: m_data[k] = wd;
          3'd4: m_data[k] = m_data[k] | wd;
          3'd5: m_data[k] = m_data[k] & ~wd;
          default: ;
        endcase
      end
    end
    if (wr && address == 3'd1) m_dir  = wd;
    if (wr && address == 3'd2) m_mask = wd;
    n       = n + 1;
    hist[n] = pad_in;
  endtask

  function automatic logic [31:0] exp_rd(input int k);
    case (address)
      3'd0:    return {24'h0, sync_at(n)};
      3'd1:    return {24'h0, m_dir};
      3'd2:    return {24'h0, m_mask};
      3'd3:    return {24'h0, m_ecap[k]};
      3'd4:    return {24'h0, m_data[k]};
      3'd5:    return {24'h0, m_data[k]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("rd_a",  rd_a, exp_rd(0));
    chk("rd_b",  rd_b, exp_rd(1));
    chk("po_a",  {24'h0, po_a}, 32'h0);
    chk("oe_a",  {24'h0, oe_a}, {24'h0, m_dir & ~m_data[0]});
    chk("po_b",  {24'h0, po_b}, {24'h0, m_data[1]});
    chk("oe_b",  {24'h0, oe_b}, {24'h0, m_dir});
    chk("irq_a", {31'h0, irq_a}, {31'h0, m_irq[0]});
    chk("irq_b", {31'h0, irq_b}, {31'h0, m_irq[1]});
  endtask

  // Called at a falling edge with this cycle's inputs already applied.
  task automatic tick();
    #1;
    check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int cnt);
    chipselect = 1'b0;
    write_n    = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      address = 3'($urandom_range(0, 7));
      tick();
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic peek(input logic [2:0] a);
    address = a;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    address     = 3'd0;
    writedata   = 32'h0;
    pad_in      = 8'hFF;
    model_reset();
    @(negedge clk);
    #1 check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // Pins high through reset: visible after two clocks, no spurious capture.
    idle(2);
    peek(3'd0);
    chk("sync_after_2", rd_a, 32'h0000_00FF);
    idle(100);
    peek(3'd3);
    chk("ecap_a_quiet", rd_a, 32'h0);
    chk("ecap_b_quiet", rd_b, 32'h0);
    chk("irq_a_quiet", {31'h0, irq_a}, 32'h0);
    chk("oe_a_quiet", {24'h0, oe_a}, 32'h0);

    // Open-drain output mapping and set/clear registers.
    wr(3'd1, 32'h03);
    wr(3'd0, 32'h01);
    chk("od_oe_02", {24'h0, oe_a}, 32'h02);
    chk("od_out_0", {24'h0, po_a}, 32'h00);
    wr(3'd5, 32'h01);
    chk("od_oe_03", {24'h0, oe_a}, 32'h03);
    wr(3'd4, 32'h02);
    chk("od_oe_01", {24'h0, oe_a}, 32'h01);
    chk("pp_out_02", {24'h0, po_b}, 32'h02);

    // Edge-to-irq latency on bit 2, then clear.
    pad_in = 8'hFB;
    idle(6);
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h04);
    idle(2);
    pad_in = 8'hFF;
    idle(3);
    peek(3'd3);
    chk("ecap_k2", rd_a, 32'h04);
    chk("irq_k2", {31'h0, irq_a}, 32'h0);
    idle(1);
    chk("irq_k3", {31'h0, irq_a}, 32'h1);
    chk("irq_b_k3", {31'h0, irq_b}, 32'h1);
    wr(3'd3, 32'h04);
    chk("irq_clr1", {31'h0, irq_a}, 32'h1);
    idle(1);
    chk("irq_clr2", {31'h0, irq_a}, 32'h0);
    chk("irq_b_clr2", {31'h0, irq_b}, 32'h0);

    // Edge arriving on the same cycle as its write-1-to-clear.
    pad_in = 8'hFE;
    idle(6);
    wr(3'd3, 32'hFF);
    idle(2);
    pad_in = 8'hFF;
    idle(2);
    wr(3'd3, 32'h01);
    peek(3'd3);
    chk("set_wins_a", rd_a, 32'h01);
    chk("set_wins_b", rd_b, 32'h01);

    // Rise-only instance ignores falls; masked capture raises no irq.
    wr(3'd2, 32'h00);
    wr(3'd3, 32'hFF);
    pad_in = 8'hDF;
    idle(6);
    peek(3'd3);
    chk("fall_b_none", rd_b, 32'h00);
    chk("fall_a_seen", rd_a, 32'h20);
    pad_in = 8'hFF;
    idle(6);
    peek(3'd3);
    chk("rise_b_20", rd_b, 32'h20);
    chk("rise_b_noirq", {31'h0, irq_b}, 32'h0);

    // Unmapped addresses.
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    peek(3'd6);
    chk("rd_addr6", rd_a, 32'h0);
    peek(3'd7);
    chk("rd_addr7", rd_b, 32'h0);
    peek(3'd1);
    chk("dir_kept", rd_a, 32'h03);

    // Random bus traffic and pin activity.
    for (int i = 0; i < 600; i++) begin
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) pad_in = pad_in ^ 8'($urandom);
      tick();
    end

    // Asynchronous reset while irq is asserted.
    wr(3'd2, 32'hFF);
    pad_in = pad_in ^ 8'h08;
    idle(5);
    chk("irq_before_rst", {31'h0, irq_a}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("irq_a_async_rst", {31'h0, irq_a}, 32'h0);
    chk("irq_b_async_rst", {31'h0, irq_b}, 32'h0);
    chk("oe_a_async_rst", {24'h0, oe_a}, 32'h0);
    model_reset();
    check_all();
    @(negedge clk);
    #1 check_all();
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) pad_in = pad_in ^ 8'($urandom);
      chipselect = 1'b0;
      address    = 3'($urandom_range(0, 7));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
